// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory, registers the returned word into IF/ID.
// Latency: 1 cycle from im_addr to id_inst. Backpressure: stall holds PC and IF/ID; redirect/flush/halt insert bubbles.

`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    redirect_en,
    input  logic [31:0]             redirect_pc,
    input  logic                    halt_req,
    output logic [`IM_ADDR_BIT-1:0] im_addr,
    input  logic [31:0]             im_inst,
    output logic [31:0]             pc,
    output logic [31:0]             id_inst,
    output logic [31:0]             id_pc4,
    output logic                    id_valid,
    output logic                    halted,
    output logic [31:0]             fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [31:0] pc_plus4;
    logic        stop;

    assign pc_plus4 = pc_q + 32'd4;
    assign stop     = halted_q | halt_req;

    always_comb begin
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        halted_d = stop;

        // Redirect outranks stall so the wrong-path word is never held in IF.
        if (stop) begin
            pc_d = pc_q;
        end else if (redirect_en) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (!stall) begin
            pc_d = pc_plus4;
        end

        if (stop || redirect_en || flush) begin
            valid_d = 1'b0;
            inst_d  = 32'h0000_0000;
        end else if (!stall) begin
            inst_d  = im_inst;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            inst_q   <= 32'h0000_0000;
            pc4_q    <= 32'h0000_0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= 32'h0000_0000;
        end else begin
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign im_addr     = pc_q[`IM_ADDR_BIT+1:2];
    assign pc          = pc_q;
    assign id_inst     = inst_q;
    assign id_pc4      = pc4_q;
    assign id_valid    = valid_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic against a behavioural fetch model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, redirect_en = 1'b0, halt_req = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [9:0]  im_addr;
    logic [31:0] im_inst, pc, id_inst, id_pc4, fetch_count;
    logic        id_valid, halted;

    logic [31:0] mem [1024];
    assign im_inst = mem[im_addr];

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .im_addr(im_addr), .im_inst(im_inst), .pc(pc), .id_inst(id_inst),
        .id_pc4(id_pc4), .id_valid(id_valid), .halted(halted), .fetch_count(fetch_count)
    );

    // Reference state
    logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
    logic        m_valid, m_halted;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // One rising edge, applying the fetch rules to the inputs present at that edge.
    task automatic model_edge();
        logic [31:0] word;
        logic [31:0] old_pc;
        old_pc = m_pc;
        word   = mem[old_pc[11:2]];
        if (m_halted || halt_req) begin
            m_valid = 1'b0; m_inst = 32'h0;
        end else begin
            if (redirect_en)
                m_pc = {redirect_pc[31:2], 2'b00};
            else if (!stall)
                m_pc = old_pc + 32'd4;
            if (redirect_en || flush) begin
                m_valid = 1'b0; m_inst = 32'h0;
            end else if (!stall) begin
                m_inst = word; m_pc4 = old_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            end
        end
        m_halted = m_halted | halt_req;
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("im_addr", {22'h0, im_addr}, {22'h0, m_pc[11:2]});
        chk("id_inst", id_inst, m_inst);
        chk("id_pc4", id_pc4, m_pc4);
        chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
        chk("halted", {31'h0, halted}, {31'h0, m_halted});
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic drive(input logic st, input logic fl, input logic re,
                         input logic [31:0] rpc, input logic hr);
        stall = st; flush = fl; redirect_en = re; redirect_pc = rpc; halt_req = hr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Called 1 time unit after a rising edge; pulses reset between edges.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] frozen_pc;
    logic [31:0] cnt_before;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        model_reset();
        #2;
        check_all();
        chk("reset_pc", pc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Sequential fetch
        drive(0, 0, 0, 32'h0, 0);
        repeat (3) tick();
        chk("seq_pc", pc, 32'h0000_000C);
        chk("seq_inst", id_inst, 32'h1000_0002);
        chk("seq_pc4", id_pc4, 32'h0000_000C);
        chk("seq_valid", {31'h0, id_valid}, 32'h1);
        chk("seq_cnt", fetch_count, 32'd3);

        // Stall at pc 0x08
        async_reset();
        repeat (2) tick();
        drive(1, 0, 0, 32'h0, 0);
        #1;
        chk("stall_no_comb_addr", {22'h0, im_addr}, 32'h2);
        repeat (2) begin
            tick();
            chk("stall_pc", pc, 32'h0000_0008);
            chk("stall_inst", id_inst, 32'h1000_0001);
            chk("stall_cnt", fetch_count, 32'd2);
        end
        drive(0, 0, 0, 32'h0, 0);
        tick();
        chk("unstall_inst", id_inst, 32'h1000_0002);

        // Redirect with simultaneous stall at pc 0x10
        tick();
        chk("pre_redir_pc", pc, 32'h0000_0010);
        drive(1, 0, 1, 32'h0000_0043, 0);
        tick();
        chk("redir_pc", pc, 32'h0000_0040);
        chk("redir_bubble", {31'h0, id_valid}, 32'h0);
        drive(0, 0, 0, 32'hDEAD_BEEF, 0);
        tick();
        chk("redir_inst", id_inst, 32'h1000_0010);
        chk("redir_pc4", id_pc4, 32'h0000_0044);

        // Flush only at pc 0x14
        drive(0, 0, 1, 32'h0000_0014, 0);
        tick();
        cnt_before = m_cnt;
        drive(0, 1, 0, 32'h0, 0);
        tick();
        chk("flush_pc", pc, 32'h0000_0018);
        chk("flush_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_inst", id_inst, 32'h0);
        chk("flush_cnt", fetch_count, cnt_before);

        // Halt, then random control noise
        drive(0, 0, 0, 32'h0, 1);
        tick();
        frozen_pc = m_pc;
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            tick();
            chk("halt_flag", {31'h0, halted}, 32'h1);
            chk("halt_pc", pc, frozen_pc);
            chk("halt_valid", {31'h0, id_valid}, 32'h0);
        end
        drive(0, 0, 0, 32'h0, 0);
        async_reset();
        chk("halt_clr", {31'h0, halted}, 32'h0);
        chk("halt_rst_pc", pc, 32'h0);

        // Wrap-around
        drive(0, 0, 1, 32'hFFFF_FFFC, 0);
        tick();
        chk("wrap_im_addr", {22'h0, im_addr}, 32'h0000_03FF);
        drive(0, 0, 0, 32'h0, 0);
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", id_pc4, 32'h0);
        chk("wrap_valid", {31'h0, id_valid}, 32'h1);
        chk("wrap_inst", id_inst, 32'h1000_03FF);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 12'($urandom)};
            drive(1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 7) == 0), rpc, 1'($urandom_range(0, 199) == 0));
            tick();
            if ((m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) begin
                drive(0, 0, 0, 32'h0, 0);
                async_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
